// File: rtl/txform_pkg.sv
// Shared defaults and FSM state encoding for the text-form line emitter.
package txform_pkg;

    localparam int         DEPTH_DEF = 16;
    localparam logic [7:0] SEP_DEF   = 8'h3A;
    localparam logic [7:0] EOL_DEF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_EMIT_LHS = 3'd2,
        ST_EMIT_SEP = 3'd3,
        ST_EMIT_RHS = 3'd4,
        ST_EMIT_NL  = 3'd5
    } state_e;

    // True for every state that presents a byte on the output.
    function automatic logic is_emit(input state_e st);
        return (st == ST_EMIT_LHS) || (st == ST_EMIT_SEP) ||
               (st == ST_EMIT_RHS) || (st == ST_EMIT_NL);
    endfunction

endpackage

// File: rtl/txform_emitter_pair_buffer.sv
// Pair storage: DEPTH x 16-bit registers {lhs, rhs}, one write port and a
// combinational read port. Contents are never reset; only written slots are read.
module pair_buffer
    import txform_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem_r [DEPTH];

    // Store one pair per write strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/txform_emitter.sv
// Captures a line of (lhs, rhs) character pairs and emits it as
// "lhs-text SEP rhs-text EOL" over a valid/ready byte stream.
module txform_emitter
    import txform_pkg::*;
#(
    parameter int         DEPTH = DEPTH_DEF,
    parameter logic [7:0] SEP   = SEP_DEF,
    parameter logic [7:0] EOL   = EOL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic [7:0] line_len,
    input  logic       pair_valid,
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       overflow
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              IW        = AW + 1;
    localparam logic [IW-1:0]   IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0]   IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]   DEPTH_IDX = IW'(DEPTH);
    localparam logic [31:0]     DEPTH_U   = 32'(DEPTH);

    state_e        state_r, nxt_state_s;
    logic [IW-1:0] idx_r, nxt_idx_s;
    logic [IW-1:0] len_r, nxt_len_s;
    logic [IW-1:0] last_idx_s;
    logic [IW-1:0] start_len_s;
    logic          too_long_s;
    logic          wr_en_s;
    logic          ovf_set_s;
    logic          accept_s;
    logic [15:0]   rd_data_s;
    logic [15:0]   byte_src_s;
    logic [7:0]    nxt_data_s;
    logic [7:0]    out_data_r;
    logic          out_valid_r;
    logic          busy_r;
    logic          overflow_r;

    pair_buffer #(.DEPTH(DEPTH), .AW(AW)) u_pair_buffer (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (idx_r[AW-1:0]),
        .wr_data ({lhs, rhs}),
        .rd_addr (nxt_idx_s[AW-1:0]),
        .rd_data (rd_data_s)
    );

    assign last_idx_s = len_r - IDX_ONE;
    assign accept_s   = out_valid_r & out_ready;
    assign too_long_s = ({24'h000000, line_len} > DEPTH_U);

    // Clamp the requested length to the buffer depth.
    always_comb begin
        start_len_s = IDX_ZERO;
        if (too_long_s) begin
            start_len_s = DEPTH_IDX;
        end else begin
            start_len_s = IW'(line_len);
        end
    end

    // Next-state, index and write-strobe logic.
    always_comb begin
        nxt_state_s = state_r;
        nxt_idx_s   = idx_r;
        nxt_len_s   = len_r;
        wr_en_s     = 1'b0;
        ovf_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (line_start) begin
                    nxt_len_s = start_len_s;
                    nxt_idx_s = IDX_ZERO;
                    ovf_set_s = too_long_s;
                    if (start_len_s == IDX_ZERO) begin
                        nxt_state_s = ST_EMIT_SEP;
                    end else begin
                        nxt_state_s = ST_CAPTURE;
                    end
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (pair_valid) begin
                    wr_en_s = 1'b1;
                    if (idx_r == last_idx_s) begin
                        nxt_state_s = ST_EMIT_LHS;
                        nxt_idx_s   = IDX_ZERO;
                    end else begin
                        nxt_idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_EMIT_LHS: begin
                if (accept_s) begin
                    if (idx_r == last_idx_s) begin
                        nxt_state_s = ST_EMIT_SEP;
                        nxt_idx_s   = IDX_ZERO;
                    end else begin
                        nxt_idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    nxt_state_s = ST_EMIT_LHS;
                end
            end
            ST_EMIT_SEP: begin
                if (accept_s) begin
                    nxt_idx_s = IDX_ZERO;
                    if (len_r == IDX_ZERO) begin
                        nxt_state_s = ST_EMIT_NL;
                    end else begin
                        nxt_state_s = ST_EMIT_RHS;
                    end
                end else begin
                    nxt_state_s = ST_EMIT_SEP;
                end
            end
            ST_EMIT_RHS: begin
                if (accept_s) begin
                    if (idx_r == last_idx_s) begin
                        nxt_state_s = ST_EMIT_NL;
                        nxt_idx_s   = IDX_ZERO;
                    end else begin
                        nxt_idx_s = idx_r + IDX_ONE;
                    end
                end else begin
                    nxt_state_s = ST_EMIT_RHS;
                end
            end
            ST_EMIT_NL: begin
                if (accept_s) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    nxt_state_s = ST_EMIT_NL;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_idx_s   = IDX_ZERO;
            end
        endcase
    end

    // Select the byte to present next cycle; the pair being written this edge
    // bypasses the buffer so a one-pair line can start emitting immediately.
    always_comb begin
        byte_src_s = rd_data_s;
        nxt_data_s = 8'h00;
        if (wr_en_s && (idx_r == nxt_idx_s)) begin
            byte_src_s = {lhs, rhs};
        end else begin
            byte_src_s = rd_data_s;
        end
        case (nxt_state_s)
            ST_EMIT_LHS: nxt_data_s = byte_src_s[15:8];
            ST_EMIT_SEP: nxt_data_s = SEP;
            ST_EMIT_RHS: nxt_data_s = byte_src_s[7:0];
            ST_EMIT_NL:  nxt_data_s = EOL;
            default:     nxt_data_s = 8'h00;
        endcase
    end

    // State, index and registered outputs; reset discards any line in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            len_r       <= IDX_ZERO;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            idx_r       <= nxt_idx_s;
            len_r       <= nxt_len_s;
            out_data_r  <= nxt_data_s;
            out_valid_r <= is_emit(nxt_state_s);
            busy_r      <= (nxt_state_s != ST_IDLE);
            overflow_r  <= overflow_r | ovf_set_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_txform_emitter.sv
// Self-checking bench for txform_emitter: randomized lines against a
// line-level reference model (first min(len,DEPTH) pairs, SEP, rhs, EOL).
module tb_txform_emitter;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic [7:0] line_len = 8'h00;
    logic       pair_valid = 1'b0;
    logic [7:0] lhs = 8'h00;
    logic [7:0] rhs = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];
    logic [7:0] pr[$];

    int cap_cyc, first_valid_cyc, stall_cycles, stall_changes;
    bit timed_out, valid_after_start;

    txform_emitter #(.DEPTH(DEPTH), .SEP(8'h3A), .EOL(8'h0A)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_len   (line_len),
        .pair_valid (pair_valid),
        .lhs        (lhs),
        .rhs        (rhs),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Collect every byte handed over; handshake values are stable at negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic random_pairs(input int n);
        pl.delete();
        pr.delete();
        for (int i = 0; i < n; i++) begin
            pl.push_back(8'($urandom_range(32'h7A, 32'h61)));
            pr.push_back(8'($urandom_range(32'h5A, 32'h41)));
        end
    endtask

    // Reference: a line of length len keeps the first min(len,DEPTH) offered pairs.
    task automatic build_expected(input int len);
        int n;
        n = (len > DEPTH) ? DEPTH : len;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
        exp_q.push_back(8'h3A);
        for (int i = 0; i < n; i++) exp_q.push_back(pr[i]);
        exp_q.push_back(8'h0A);
    endtask

    // Drive one line: start pulse, offer all pairs in pl/pr, run until idle.
    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1 from first byte.
    task automatic send_line(input int len, input int ready_mode, input int gap_pct, input bit poke);
        int  n_eff, sent, cyc, emit_i;
        bit  pv, prev_stall;
        logic [7:0] prev_data;
        n_eff = (len > DEPTH) ? DEPTH : len;
        sent = 0; cyc = 0; emit_i = 0;
        cap_cyc = -1; first_valid_cyc = -1;
        stall_cycles = 0; stall_changes = 0; timed_out = 1'b0;
        got_q.delete();
        line_len = 8'(len);
        line_start = 1'b1;
        out_ready = 1'b1;
        step();
        line_start = 1'b0;
        valid_after_start = out_valid;
        if (n_eff == 0) cap_cyc = 0;
        if (out_valid) first_valid_cyc = 0;
        for (int guard = 0; guard < 3000; guard++) begin
            if (sent < pl.size() && ($urandom_range(99) >= gap_pct)) begin
                pair_valid = 1'b1; lhs = pl[sent]; rhs = pr[sent];
            end else begin
                pair_valid = 1'b0; lhs = 8'($urandom); rhs = 8'($urandom);
            end
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(3) != 0);
                default: begin
                    out_ready = (out_valid && (emit_i == 1 || emit_i == 2)) ? 1'b0 : 1'b1;
                    if (out_valid) emit_i++;
                end
            endcase
            if (poke && busy && ($urandom_range(3) == 0)) begin
                line_start = 1'b1; line_len = 8'($urandom);
            end else begin
                line_start = 1'b0;
            end
            pv = pair_valid;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            step();
            cyc++;
            if (pv) begin
                sent++;
                if (sent == n_eff) cap_cyc = cyc;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                stall_cycles++;
                if (out_data !== prev_data || out_valid !== 1'b1) stall_changes++;
            end
            if (sent >= pl.size() && !busy) break;
            if (guard == 2999) timed_out = 1'b1;
        end
        pair_valid = 1'b0; line_start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] gb;
        pl.delete(); pr.delete();
        pl.push_back(8'h61); pl.push_back(8'h62); pl.push_back(8'h63);
        pr.push_back(8'h41); pr.push_back(8'h42); pr.push_back(8'h43);
        send_line(3, 0, 0, 1'b0);
        build_expected(3);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL basic_timeout: line did not finish"); end
        tests_run++; if (got_q.size() != 8) begin tests_failed++; $display("FAIL basic_count: got %0d want 8", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++; if (gb !== exp_q[i]) begin tests_failed++; $display("FAIL basic_byte[%0d]: got %h want %h", i, gb, exp_q[i]); end
        end
        tests_run++; if (first_valid_cyc != 3 || cap_cyc != 3) begin tests_failed++; $display("FAIL basic_latency: first valid cycle %0d capture cycle %0d want 3", first_valid_cyc, cap_cyc); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_zero_len();
        pl.delete(); pr.delete();
        send_line(0, 0, 0, 1'b0);
        tests_run++; if (valid_after_start !== 1'b1) begin tests_failed++; $display("FAIL zero_first_valid: got %b want 1", valid_after_start); end
        tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL zero_count: got %0d want 2", got_q.size()); end
        tests_run++; if (got_q.size() < 2 || got_q[0] !== 8'h3A || got_q[1] !== 8'h0A) begin
            tests_failed++; $display("FAIL zero_bytes: got %p want 3a 0a", got_q);
        end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] gb;
        random_pairs(20);
        send_line(20, 0, 0, 1'b0);
        build_expected(20);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        tests_run++; if (got_q.size() != 34) begin tests_failed++; $display("FAIL ovf_count: got %0d want 34", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++; if (gb !== exp_q[i]) begin tests_failed++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, gb, exp_q[i]); end
        end
        random_pairs(2);
        send_line(2, 1, 20, 1'b0);
        build_expected(2);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL ovf_next_line: got %p want %p", got_q, exp_q); end
    endtask

    task automatic test_stall();
        logic [7:0] gb;
        random_pairs(4);
        send_line(4, 2, 0, 1'b0);
        build_expected(4);
        tests_run++; if (stall_cycles != 2) begin tests_failed++; $display("FAIL stall_cycles: got %0d want 2", stall_cycles); end
        tests_run++; if (stall_changes != 0) begin tests_failed++; $display("FAIL stall_stable: got %0d changes want 0", stall_changes); end
        tests_run++; if (got_q.size() != 10) begin tests_failed++; $display("FAIL stall_count: got %0d want 10", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            gb = (i < got_q.size()) ? got_q[i] : 8'hxx;
            tests_run++; if (gb !== exp_q[i]) begin tests_failed++; $display("FAIL stall_byte[%0d]: got %h want %h", i, gb, exp_q[i]); end
        end
    endtask

    task automatic test_gaps_busy_start();
        int n;
        random_pairs(6);
        send_line(6, 1, 40, 1'b1);
        build_expected(6);
        tests_run++; if (timed_out) begin tests_failed++; $display("FAIL gaps_timeout: line did not finish"); end
        tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL gaps_bytes: got %p want %p", got_q, exp_q); end
        n = got_q.size();
        for (int i = 0; i < 10; i++) step();
        tests_run++; if (got_q.size() != n) begin tests_failed++; $display("FAIL gaps_no_second_line: got %0d bytes want %0d", got_q.size(), n); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL gaps_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_random();
        int len;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(20);
            random_pairs(len + $urandom_range(2));
            send_line(len, 1, 25, 1'b0);
            build_expected(len);
            tests_run++; if (got_q.size() != 2 * ((len > DEPTH) ? DEPTH : len) + 2) begin
                tests_failed++; $display("FAIL rand_count[%0d]: len %0d got %0d bytes", k, len, got_q.size());
            end
            tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL rand_bytes[%0d]: got %p want %p", k, got_q, exp_q); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit reached;
        random_pairs(4);
        build_expected(4);
        got_q.delete();
        line_len = 8'd4; line_start = 1'b1; out_ready = 1'b1;
        step();
        line_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pair_valid = 1'b1; lhs = pl[i]; rhs = pr[i];
            step();
        end
        pair_valid = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (got_q.size() >= 6) begin reached = 1'b1; break; end
            step();
        end
        tests_run++; if (!reached) begin tests_failed++; $display("FAIL rstmid_reach_rhs: got %0d bytes want 6", got_q.size()); end
        tests_run++; if (got_q.size() < 6 || got_q[5] !== exp_q[5]) begin tests_failed++; $display("FAIL rstmid_prefix: got %p want prefix of %p", got_q, exp_q); end
        rst = 1'b1;
        step();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_out_data: got %h want 00", out_data); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
        rst = 1'b0;
        n = got_q.size();
        for (int i = 0; i < 5; i++) step();
        tests_run++; if (got_q.size() != n) begin tests_failed++; $display("FAIL rstmid_no_bytes: got %0d bytes want %0d", got_q.size(), n); end
        pl.delete(); pr.delete();
        pl.push_back(8'h78); pr.push_back(8'h58);
        send_line(1, 0, 0, 1'b0);
        exp_q.delete();
        exp_q.push_back(8'h78); exp_q.push_back(8'h3A); exp_q.push_back(8'h58); exp_q.push_back(8'h0A);
        tests_run++; if (got_q != exp_q) begin tests_failed++; $display("FAIL rstmid_new_line: got %p want %p", got_q, exp_q); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_stall();
        test_gaps_busy_start();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/txform_emitter.md
TXFORM_EMITTER -- requirements
Module: txform_emitter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the maximum number of character pairs buffered per line.
REQ-002 The block SHALL have parameter SEP, default 8'h3A (':'), giving the byte emitted between the LHS and RHS text.
REQ-003 The block SHALL have parameter EOL, default 8'h0A (newline), giving the byte emitted at the end of each line.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port line_start, input, 1 bit: one-cycle request to begin capturing a line.
REQ-007 The block SHALL have port line_len, input, 8 bits: number of pairs in the line, sampled with line_start.
REQ-008 The block SHALL have port pair_valid, input, 1 bit: qualifies lhs/rhs in the current cycle.
REQ-009 The block SHALL have port lhs, input, 8 bits: input-side ASCII character.
REQ-010 The block SHALL have port rhs, input, 8 bits: transformed ASCII character.
REQ-011 The block SHALL have port out_data, output, 8 bits: emitted byte.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid byte.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the sink accepts the byte when both out_valid and out_ready are high.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag for a line_len greater than DEPTH.

Function
REQ-016 The FSM SHALL have the states IDLE, CAPTURE, EMIT_LHS, EMIT_SEP, EMIT_RHS and EMIT_NL.
REQ-017 On an edge in IDLE with line_start=1, the block SHALL latch len = min(line_len, DEPTH), clear the pair index, and go to CAPTURE; if len=0 it SHALL go directly to EMIT_SEP instead.
REQ-018 The block SHALL set overflow on the same edge when line_len > DEPTH; overflow SHALL stay set until rst.
REQ-019 In CAPTURE, each edge with pair_valid=1 SHALL store {lhs,rhs} at the current index and increment the index.
REQ-020 CAPTURE SHALL move to EMIT_LHS on the edge that stores pair len-1; pairs offered after that edge SHALL be dropped.
REQ-021 On an overflowed line, upstream pairs beyond DEPTH SHALL arrive after CAPTURE ends and SHALL be ignored.
REQ-022 The block SHALL ignore pair_valid in every state other than CAPTURE.
REQ-023 The block SHALL ignore line_start in every state other than IDLE, with no queuing.
REQ-024 out_valid SHALL be high in the EMIT_* states and low otherwise.
REQ-025 The first out_valid SHALL occur in the cycle after the edge that captures the final pair (or after the accepting edge when len=0).
REQ-026 EMIT_LHS SHALL emit lhs[0..len-1] in order, EMIT_SEP SHALL emit SEP, EMIT_RHS SHALL emit rhs[0..len-1] in order, and EMIT_NL SHALL emit EOL.
REQ-027 Each state/index SHALL advance only on the edge where out_valid and out_ready are both high.
REQ-028 While out_ready=0, out_data SHALL be held stable.
REQ-029 After the EOL byte is accepted, the block SHALL return to IDLE; line_start SHALL be accepted no earlier than the following edge.
REQ-030 All indices SHALL be log2(DEPTH)+1 bits wide, all comparisons SHALL be unsigned, and indices SHALL not wrap within a line.
REQ-031 A line of len N SHALL produce exactly 2N+2 output bytes.

Reset
REQ-032 While rst=1 on an edge, the block SHALL enter IDLE and SHALL force out_valid=0, out_data=8'h00, busy=0 and overflow=0.
REQ-033 Reset SHALL take priority over every other input, including in the middle of CAPTURE or EMIT.
REQ-034 A partially captured or emitted line SHALL be discarded on reset, with no further bytes after reset.
REQ-035 Buffer contents SHALL need no reset.

Structure
REQ-036 A shared package txform_pkg SHALL hold the DEPTH, SEP and EOL defaults and the FSM state encoding.
REQ-037 The pair storage SHALL be one sub-module, pair_buffer: DEPTH x 16-bit registers, with one write port and a combinational read port.

Verification
REQ-038 The bench SHALL cover: line_len=3, pairs (a,A),(b,B),(c,C), out_ready=1 -> bytes "abc:ABC\n", 8 bytes, with out_valid first high one cycle after the third pair.
REQ-039 The bench SHALL cover: line_len=0 -> exactly 8'h3A, 8'h0A, then busy=0.
REQ-040 The bench SHALL cover: line_len=20 with 20 pairs offered -> overflow=1, 34 bytes, pairs 17-20 absent, and overflow still 1 after the next line.
REQ-041 The bench SHALL cover: out_ready toggled 1,0,0,1 during EMIT_LHS -> out_data stable while stalled, with no byte lost or repeated.
REQ-042 The bench SHALL cover: pair_valid gaps during CAPTURE, plus line_start pulses while busy -> output unchanged and no second line started.
REQ-043 The bench SHALL cover: rst asserted mid-EMIT_RHS -> out_valid=0 next cycle and IDLE, after which a new line_len=1 (x,X) yields "x:X\n".
